// File: rtl/axi4_stream_pkt_gen.sv
// AXI4-Stream packet generator: on start, emits a burst of packets carrying an incrementing
// data pattern, with a programmable packet count, packet length, seed and inter-packet gap.
module axi4_stream_pkt_gen #(
  parameter int DATA_WIDTH = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  num_pkts,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  input  logic [GAP_WIDTH-1:0]  gap_cycles,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tlast,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  pkts_sent
);

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] num_cfg;
  logic [LEN_WIDTH-1:0] len_cfg;
  logic [GAP_WIDTH-1:0] gap_cfg;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [GAP_WIDTH-1:0] gap_cnt;

  // Single FSM: every output is a register that is updated alongside the state transitions.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tlast   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pkts_sent <= '0;
      num_cfg   <= '0;
      len_cfg   <= '0;
      gap_cfg   <= '0;
      beat_cnt  <= '0;
      gap_cnt   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            num_cfg   <= num_pkts;
            len_cfg   <= pkt_len;
            gap_cfg   <= gap_cycles;
            pkts_sent <= '0;
            beat_cnt  <= '0;
            m_tdata   <= seed;
            if (num_pkts == '0 || pkt_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state    <= SEND;
              m_tvalid <= 1'b1;
              m_tlast  <= (pkt_len == LEN_WIDTH'(1));
              busy     <= 1'b1;
            end
          end
        end
        SEND: begin
          if (m_tready) begin
            m_tdata <= m_tdata + DATA_WIDTH'(1);
            if (!m_tlast) begin
              // Next beat index is beat_cnt+1; it is the last one when it equals len_cfg-1.
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
              m_tlast  <= (beat_cnt + LEN_WIDTH'(2) == len_cfg);
            end else begin
              pkts_sent <= pkts_sent + CNT_WIDTH'(1);
              beat_cnt  <= '0;
              if (pkts_sent + CNT_WIDTH'(1) == num_cfg) begin
                state    <= DONE;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                busy     <= 1'b0;
                done     <= 1'b1;
              end else if (gap_cfg == '0) begin
                m_tlast <= (len_cfg == LEN_WIDTH'(1));
              end else begin
                state    <= GAP;
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
                gap_cnt  <= gap_cfg;
              end
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_WIDTH'(1)) begin
            state    <= SEND;
            m_tvalid <= 1'b1;
            m_tlast  <= (len_cfg == LEN_WIDTH'(1));
          end else begin
            gap_cnt <= gap_cnt - GAP_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_stream_pkt_gen.sv
// Self-checking bench for axi4_stream_pkt_gen: a queue-based burst model checked every cycle,
// plus directed tests with literal expectations.
module tb_axi4_stream_pkt_gen;

  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_pkts;
  logic [7:0]  pkt_len;
  logic [3:0]  gap_cycles;
  logic [15:0] seed;
  logic        m_tvalid;
  logic        m_tready;
  logic [15:0] m_tdata;
  logic        m_tlast;
  logic        busy;
  logic        done;
  logic [7:0]  pkts_sent;

  int total = 0;
  int bad   = 0;

  beat_t q[$];
  beat_t log_q[$];
  bit    rnd_ready = 0;
  bit    busy_exp, done_exp, next_busy, next_done, exp_valid, ready_now;
  int    pkts_exp, gap_left, gap_cfg_m;
  beat_t item;
  int    lat;

  axi4_stream_pkt_gen #(
    .DATA_WIDTH(16), .LEN_WIDTH(8), .CNT_WIDTH(8), .GAP_WIDTH(4)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .num_pkts(num_pkts), .pkt_len(pkt_len),
    .gap_cycles(gap_cycles), .seed(seed), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tdata(m_tdata), .m_tlast(m_tlast), .busy(busy), .done(done), .pkts_sent(pkts_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // Model: an accepted start expands into the full list of expected beats; each cycle the DUT
  // outputs are compared against the list head and against the expected valid/gap/busy/done timing.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      busy_exp = 0;
      done_exp = 0;
      pkts_exp = 0;
      gap_left = 0;
      m_tready = 1'b1;
    end else begin
      exp_valid = busy_exp && (q.size() > 0) && (gap_left == 0);
      checkOutput("busy", 32'(busy), 32'(busy_exp));
      checkOutput("done", 32'(done), 32'(done_exp));
      checkOutput("pkts_sent", 32'(pkts_sent), 32'(pkts_exp));
      checkOutput("tvalid", 32'(m_tvalid), 32'(exp_valid));
      if (exp_valid && m_tvalid) begin
        checkOutput("tdata", 32'(m_tdata), 32'(q[0].data));
        checkOutput("tlast", 32'(m_tlast), 32'(q[0].last));
      end else if (!m_tvalid) begin
        checkOutput("tlast_idle", 32'(m_tlast), 32'd0);
      end
      next_busy = busy_exp;
      next_done = 0;
      if (gap_left > 0) gap_left--;
      ready_now = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      m_tready  = ready_now;
      if (m_tvalid && ready_now) log_q.push_back('{data: m_tdata, last: m_tlast});
      if (exp_valid && ready_now) begin
        item = q.pop_front();
        if (item.last) begin
          pkts_exp++;
          if (q.size() == 0) begin
            next_busy = 0;
            next_done = 1;
          end else begin
            gap_left = gap_cfg_m;
          end
        end
      end
      if (start && !busy_exp && !done_exp) begin
        pkts_exp  = 0;
        gap_left  = 0;
        gap_cfg_m = int'(gap_cycles);
        q.delete();
        for (int p = 0; p < int'(num_pkts); p++) begin
          for (int b = 0; b < int'(pkt_len); b++) begin
            item.data = 16'(int'(seed) + p * int'(pkt_len) + b);
            item.last = (b == int'(pkt_len) - 1);
            q.push_back(item);
          end
        end
        if (num_pkts == 0 || pkt_len == 0) next_done = 1;
        else next_busy = 1;
      end
      busy_exp = next_busy;
      done_exp = next_done;
    end
  end

  // Runs one burst; optionally pulses a conflicting start mid-burst. Returns cycles from accept to done.
  task automatic applyStimulus(input int n, input int len, input int gap, input logic [15:0] sd,
                               input bit rnd, input int inject, input int exp_pkts, output int latency);
    latency = -1;
    log_q.delete();
    rnd_ready = rnd;
    @(posedge clk);
    #2;
    num_pkts   = 8'(n);
    pkt_len    = 8'(len);
    gap_cycles = 4'(gap);
    seed       = sd;
    start      = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) start = 1'b0;
      if (inject > 0 && i == inject) begin
        start    = 1'b1;
        seed     = 16'h0900;
        num_pkts = 8'd5;
        pkt_len  = 8'd7;
      end
      if (inject > 0 && i == inject + 1) start = 1'b0;
      if (done) begin
        latency = i;
        break;
      end
    end
    start = 1'b0;
    if (latency < 0) begin
      checkOutput("done_timeout", 32'd0, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #2 rst = 1'b0;
    end else begin
      checkOutput("pkts_final", 32'(pkts_sent), 32'(exp_pkts));
      checkOutput("beat_count", 32'(log_q.size()), 32'(n * len));
    end
    rnd_ready = 0;
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_pkts = '0; pkt_len = '0; gap_cycles = '0; seed = '0;
    m_tready = 1'b1;
    #3;
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
    checkOutput("rst_busy_done", 32'({busy, done, m_tlast}), 32'd0);
    checkOutput("rst_pkts", 32'(pkts_sent), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    $display("[TB] T1 single packet");
    applyStimulus(1, 4, 0, 16'h0010, 0, 0, 1, lat);
    checkOutput("t1_latency", 32'(lat), 32'd4);
    checkOutput("t1_b0", 32'(log_q[0].data), 32'h10);
    checkOutput("t1_b3", 32'(log_q[3].data), 32'h13);
    checkOutput("t1_last2", 32'(log_q[2].last), 32'd0);
    checkOutput("t1_last3", 32'(log_q[3].last), 32'd1);

    $display("[TB] T2 back-to-back with wrap");
    applyStimulus(2, 3, 0, 16'hFFFE, 0, 0, 2, lat);
    checkOutput("t2_latency", 32'(lat), 32'd6);
    checkOutput("t2_b1", 32'(log_q[1].data), 32'hFFFF);
    checkOutput("t2_b2", 32'(log_q[2].data), 32'h0000);
    checkOutput("t2_b5", 32'(log_q[5].data), 32'h0003);
    checkOutput("t2_last", 32'({log_q[2].last, log_q[4].last, log_q[5].last}), 32'b101);

    $display("[TB] T3 gap with backpressure");
    applyStimulus(3, 2, 2, 16'h1234, 1, 0, 3, lat);
    checkOutput("t3_b5", 32'(log_q[5].data), 32'h1239);

    $display("[TB] T4 degenerate bursts");
    applyStimulus(0, 4, 1, 16'h0A00, 0, 0, 0, lat);
    checkOutput("t4_n0_latency", 32'(lat), 32'd0);
    applyStimulus(3, 0, 1, 16'h0B00, 0, 0, 0, lat);
    checkOutput("t4_l0_latency", 32'(lat), 32'd0);
    applyStimulus(2, 1, 0, 16'h0042, 0, 0, 2, lat);
    checkOutput("t4_l1_latency", 32'(lat), 32'd2);
    checkOutput("t4_l1_last", 32'({log_q[0].last, log_q[1].last}), 32'b11);
    checkOutput("t4_l1_b1", 32'(log_q[1].data), 32'h0043);

    $display("[TB] T5 start while busy");
    applyStimulus(2, 3, 1, 16'h0500, 0, 3, 2, lat);
    checkOutput("t5_b5", 32'(log_q[5].data), 32'h0505);

    $display("[TB] T6 reset mid-packet");
    log_q.delete();
    @(posedge clk);
    #2;
    num_pkts = 8'd1; pkt_len = 8'd5; gap_cycles = 4'd0; seed = 16'h0100; start = 1'b1;
    @(posedge clk);
    #2 start = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("t6_tdata", 32'(m_tdata), 32'd0);
    checkOutput("t6_flags", 32'({busy, done, m_tlast}), 32'd0);
    checkOutput("t6_pkts", 32'(pkts_sent), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    applyStimulus(1, 3, 0, 16'h0200, 0, 0, 1, lat);
    checkOutput("t6_b0", 32'(log_q[0].data), 32'h0200);
    checkOutput("t6_b2", 32'(log_q[2].data), 32'h0202);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
